matvec_mac_sequencer: RTL and testbench
=======================================

Name: matvec_mac_sequencer

Overview:
Sequences a matrix-vector product, one row at a time, on a single shared unsigned multiply-accumulate datapath. One output element is produced per matrix row. On start, the block captures an Nrows x Ndata matrix and an Ndata vector. It runs Ndata MAC steps per row and hands each row result out over a valid/ready handshake. It sits above the scalar-product MAC in the MATRIX course flow and is the controller that turns that datapath into a matrix engine.

Parameters:
Nbits, 4, width of each unsigned matrix/vector element
Ndata, 4, elements per row (vector length); must be >= 2
Nrows, 4, number of matrix rows (outputs per run); must be >= 1
(localparam ACCW = 2*Nbits + $clog2(Ndata), accumulator/result width; 10 for the defaults)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
M  input  Nrows*Ndata*Nbits  matrix; row r at M[r*Ndata*Nbits +: Ndata*Nbits], element k of a row at [k*Nbits +: Nbits]
V  input  Ndata*Nbits  vector; element k at V[k*Nbits +: Nbits]
busy  output  1  high from the cycle after start is accepted until done
out_data  output  ACCW  row result, sum over k of M[r][k]*V[k], unsigned
out_row  output  $clog2(Nrows) (min 1)  index r of the row in out_data
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge
done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, out_valid, done=0; out_data, out_row, accumulator, element counter, row counter=0. The captured M/V registers do not need a reset.
- Reset asserted mid-run aborts the run immediately. No done pulse. After release, the block waits in IDLE for a new start.
- FSM states and transitions:
  - IDLE: start=1 at edge T captures M and V into internal registers, clears the accumulator, sets row=0 and k=0, and moves to MAC.
  - MAC: during cycles T+1 .. T+Ndata, acc += Mcap[row][k]*Vcap[k] and k increments. After the k=Ndata-1 step, the state moves to EMIT. out_data is loaded with the final sum, out_row with row, and out_valid is set.
  - EMIT: out_valid=1, and out_data/out_row stay stable until handshake.
    - On handshake with row<Nrows-1: out_valid=0, row++, acc=0, k=0, go to MAC.
    - On handshake with row=Nrows-1: out_valid=0, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 next, then go to IDLE.
- Latency with out_ready tied high: row r has out_valid=1 in cycle T+(r+1)*(Ndata+1). done is high in cycle T+Nrows*(Ndata+1)+1. busy is high in cycles T+1 .. T+Nrows*(Ndata+1).
- Backpressure: with out_ready=0, the block stalls in EMIT indefinitely. No MAC step occurs and the output is not overwritten.
- start while busy or in DONE is ignored and not queued. Changes to M or V after capture do not affect the run.
- Arithmetic: unsigned only. Products are 2*Nbits wide. ACCW is sized so Ndata full-scale products never overflow, so no wrap and no saturation occur.
- out_data/out_row keep the last emitted value after out_valid drops, until the next EMIT load.

Test Plan:
- Single row (Nrows=1 instance or row 0 check): row {2,3,2,1}, meaning M[15:0]=16'h2321, and V={1,4,5,6}=16'h1456, start at T -> out_valid at T+5, out_data=30, out_row=0.
- Full-scale: all rows = 16'hFFFF, V=16'hFFFF -> every out_data=900, with no overflow at ACCW=10. Row {1,15,15,15} with V {1,15,15,15} -> 676.
- Four-row run with out_ready=1: rows are identity-like, row r with element r=1 and others 0, and V={1,4,5,6}. Expect out_data 6,5,4,1 at T+5, T+10, T+15, T+20 with out_row 0..3, then done at T+21 and busy low from T+21.
- Backpressure: out_ready=0 for 7 cycles during row 1 EMIT -> out_data/out_row stay constant and out_valid stays 1. Completion shifts by 7 cycles and results are unchanged.
- start pulsed during busy, and M/V changed mid-run -> ignored; results match the values captured at the original start.
- reset pulled low during MAC of row 2 -> all outputs are 0 in the same cycle and there is no done pulse. After release plus a new start, a full correct run follows.

Source files
------------

// File: rtl/matvec_mac_sequencer.sv
// Row-at-a-time matrix-vector sequencer over one shared unsigned MAC datapath.
// Each row result is offered on a valid/ready handshake; done pulses after the last row.
module matvec_mac_sequencer #(
  parameter  int unsigned Nbits = 4,
  parameter  int unsigned Ndata = 4,
  parameter  int unsigned Nrows = 4,
  localparam int unsigned ACCW  = 2*Nbits + $clog2(Ndata),
  localparam int unsigned RW    = (Nrows > 1) ? $clog2(Nrows) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [Nrows*Ndata*Nbits-1:0]  M,
  input  logic [Ndata*Nbits-1:0]        V,
  output logic                          busy,
  output logic [ACCW-1:0]               out_data,
  output logic [RW-1:0]                 out_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done
);

  localparam int unsigned KW = $clog2(Ndata);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

  state_t          state, state_n;
  logic [ACCW-1:0] acc, acc_n, out_data_n, sum;
  logic [KW-1:0]   k, k_n;
  logic [RW-1:0]   row, row_n, out_row_n;
  logic            busy_n, out_valid_n, done_n, cap_en;

  logic [Nbits-1:0] mcap [Nrows][Ndata];
  logic [Nbits-1:0] vcap [Ndata];

  // One MAC step: products are zero-extended so the sum never wraps
  assign sum = acc + ACCW'(mcap[row][k]) * ACCW'(vcap[k]);

  // Operand snapshot taken on accepted start; later M/V changes are invisible to the run
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int r = 0; r < int'(Nrows); r++)
        for (int j = 0; j < int'(Ndata); j++)
          mcap[r][j] <= M[(r*int'(Ndata) + j)*int'(Nbits) +: Nbits];
      for (int j = 0; j < int'(Ndata); j++)
        vcap[j] <= V[j*int'(Nbits) +: Nbits];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      k         <= '0;
      row       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      k         <= k_n;
      row       <= row_n;
      busy      <= busy_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_row   <= out_row_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    k_n         = k;
    row_n       = row;
    busy_n      = busy;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_row_n   = out_row;
    done_n      = 1'b0;
    cap_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cap_en  = 1'b1;
          acc_n   = '0;
          k_n     = '0;
          row_n   = '0;
          busy_n  = 1'b1;
          state_n = S_MAC;
        end
      end
      S_MAC: begin
        acc_n = sum;
        k_n   = k + KW'(1);
        if (k == KW'(Ndata - 1)) begin
          k_n         = '0;
          out_data_n  = sum;
          out_row_n   = row;
          out_valid_n = 1'b1;
          state_n     = S_EMIT;
        end
      end
      S_EMIT: begin
        // Stalled here with no MAC activity until the consumer takes the row
        if (out_ready) begin
          out_valid_n = 1'b0;
          if (row == RW'(Nrows - 1)) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            row_n   = row + RW'(1);
            acc_n   = '0;
            k_n     = '0;
            state_n = S_MAC;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matvec_mac_sequencer.sv
// Directed bench for matvec_mac_sequencer at default parameters (4-bit, 4x4, ACCW=10).
module tb_matvec_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] M;
  logic [15:0] V;
  logic        busy;
  logic [9:0]  out_data;
  logic [1:0]  out_row;
  logic        out_valid;
  logic        out_ready;
  logic        done;

  int checks = 0;
  int failures = 0;

  // Results of the most recent collected run; cycle numbers are relative to the start edge
  int res_data [8];
  int res_row  [8];
  int res_cyc  [8];
  int nres, done_cyc, done_cnt, busy_first, busy_last, hold_viol;

  localparam logic [63:0] M_IDENT = 64'h1000_0100_0010_0001;
  localparam logic [15:0] V_BASE  = 16'h1456;

  matvec_mac_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .M(M), .V(V),
    .busy(busy), .out_data(out_data), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs cycles after a start, recording handshakes; optional stall, start pokes and M/V change
  task automatic collect(input int stall_row, input int stall_n, input int p1, input int p2,
                         input int budget);
    int stall_left;
    bit stall_active;
    int hold_d, hold_r;
    nres = 0; done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; hold_viol = 0;
    stall_left = stall_n; stall_active = 0; hold_d = 0; hold_r = 0;
    for (int i = 0; i < 8; i++) begin res_data[i] = -1; res_row[i] = -1; res_cyc[i] = -1; end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == p1) || (c == p2);
      if (c == p1) begin M = '1; V = '1; end
      if (stall_left > 0 && (stall_active || (out_valid && int'(out_row) == stall_row))) begin
        if (!stall_active) begin
          stall_active = 1; hold_d = int'(out_data); hold_r = int'(out_row);
        end else if (!out_valid || int'(out_data) != hold_d || int'(out_row) != hold_r) begin
          hold_viol++;
        end
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && nres < 8) begin
        res_data[nres] = int'(out_data); res_row[nres] = int'(out_row); res_cyc[nres] = c;
        nres++;
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b1; M = M_IDENT; V = V_BASE;
    #1;
    checks++;
    if ({busy, out_valid, done, out_data, out_row} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, out_valid, done, out_data, out_row});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start busy=%b valid=%b exp=0,0", busy, out_valid);
    end
  endtask

  task automatic test_single_row();
    M = 64'h0000_0000_0000_2321; V = V_BASE;
    start_run();
    collect(-1, 0, -1, -1, 60);
    checks++;
    if (res_data[0] !== 30 || res_row[0] !== 0 || res_cyc[0] !== 5) begin
      failures++;
      $display("FAIL single_row got data=%0d row=%0d cyc=%0d exp 30,0,5",
               res_data[0], res_row[0], res_cyc[0]);
    end
    checks++;
    if (res_data[1] !== 0 || res_data[2] !== 0 || res_data[3] !== 0) begin
      failures++;
      $display("FAIL single_row_zero_rows got=%0d,%0d,%0d exp 0,0,0",
               res_data[1], res_data[2], res_data[3]);
    end
  endtask

  task automatic test_full_scale();
    M = '1; V = '1;
    start_run();
    collect(-1, 0, -1, -1, 60);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_data[i] !== 900) begin
        failures++;
        $display("FAIL full_scale[%0d] got=%0d exp=900", i, res_data[i]);
      end
    end
    M = {4{16'h1FFF}}; V = 16'h1FFF;
    start_run();
    collect(-1, 0, -1, -1, 60);
    checks++;
    if (res_data[0] !== 676 || res_data[3] !== 676) begin
      failures++;
      $display("FAIL mixed_scale got=%0d,%0d exp=676,676", res_data[0], res_data[3]);
    end
  endtask

  task automatic test_four_row();
    int exp_d [4] = '{6, 5, 4, 1};
    M = M_IDENT; V = V_BASE;
    start_run();
    collect(-1, 0, -1, -1, 60);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_data[i] !== exp_d[i] || res_row[i] !== i || res_cyc[i] !== 5*(i+1)) begin
        failures++;
        $display("FAIL four_row[%0d] got data=%0d row=%0d cyc=%0d exp %0d,%0d,%0d",
                 i, res_data[i], res_row[i], res_cyc[i], exp_d[i], i, 5*(i+1));
      end
    end
    checks++;
    if (done_cyc !== 21 || done_cnt !== 1) begin
      failures++;
      $display("FAIL four_row_done got cyc=%0d cnt=%0d exp 21,1", done_cyc, done_cnt);
    end
    checks++;
    if (busy_first !== 1 || busy_last !== 20) begin
      failures++;
      $display("FAIL four_row_busy got first=%0d last=%0d exp 1,20", busy_first, busy_last);
    end
  endtask

  task automatic test_backpressure();
    int exp_d [4] = '{6, 5, 4, 1};
    int exp_c [4] = '{5, 17, 22, 27};
    M = M_IDENT; V = V_BASE;
    start_run();
    collect(1, 7, -1, -1, 80);
    checks++;
    if (hold_viol !== 0) begin
      failures++;
      $display("FAIL bp_hold got violations=%0d exp=0", hold_viol);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_data[i] !== exp_d[i] || res_cyc[i] !== exp_c[i]) begin
        failures++;
        $display("FAIL bp_row[%0d] got data=%0d cyc=%0d exp %0d,%0d",
                 i, res_data[i], res_cyc[i], exp_d[i], exp_c[i]);
      end
    end
    checks++;
    if (done_cyc !== 28 || busy_last !== 27) begin
      failures++;
      $display("FAIL bp_done got done=%0d busy_last=%0d exp 28,27", done_cyc, busy_last);
    end
  endtask

  task automatic test_start_ignored();
    int exp_d [4] = '{6, 5, 4, 1};
    M = M_IDENT; V = V_BASE;
    start_run();
    collect(-1, 0, 3, 21, 60);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL ignore_row[%0d] got=%0d exp=%0d", i, res_data[i], exp_d[i]);
      end
    end
    checks++;
    if (done_cyc !== 21 || busy_last !== 20 || done_cnt !== 1 || nres !== 4) begin
      failures++;
      $display("FAIL ignore_timing got done=%0d busy_last=%0d cnt=%0d n=%0d exp 21,20,1,4",
               done_cyc, busy_last, done_cnt, nres);
    end
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    M = M_IDENT; V = V_BASE;
    start_run();
    collect(-1, 0, -1, -1, 12);
    checks++;
    if (nres !== 2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_precond got n=%0d busy=%b exp 2,1", nres, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, done, out_data, out_row} !== 15'd0) begin
      failures++;
      $display("FAIL abort_outputs got=%b exp=0", {busy, out_valid, done, out_data, out_row});
    end
    saw_done = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got activity=%b exp=0", saw_done);
    end
    V = 16'h2222;
    start_run();
    collect(-1, 0, -1, -1, 60);
    checks++;
    if (res_data[0] !== 2 || res_data[3] !== 2 || res_row[3] !== 3 || done_cyc !== 21) begin
      failures++;
      $display("FAIL rerun got d0=%0d d3=%0d r3=%0d done=%0d exp 2,2,3,21",
               res_data[0], res_data[3], res_row[3], done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_full_scale();
    test_four_row();
    test_backpressure();
    test_start_ignored();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
